adc_sample_fifo: RTL

//  Capture buffer directly downstream of vco_adc: accepts each decimated sinc sample
//  (data_in/data_valid_in = vco_adc data_out/data_valid_out) into a synchronous FIFO.

---
 rtl/adc_sample_fifo_pkg.sv | 7 +
 rtl/adc_sample_fifo_if.sv | 30 +++
 rtl/adc_sample_fifo_mem.sv | 24 ++
 rtl/adc_sample_fifo.sv | 57 +++++
 4 files changed

// File: rtl/adc_sample_fifo_pkg.sv
// adc_sample_fifo_pkg: shared widths and depths for the vco_adc capture FIFO
package adc_sample_fifo_pkg;
  localparam int ADC_DATA_W = 32;
  localparam int FIFO_DEPTH = 16;
  localparam int FIFO_ADDR_W = 4;
  localparam int FIFO_DROP_W = 16;
endpackage

// File: rtl/adc_sample_fifo_if.sv
// adc_sample_fifo_if: sample write, registered read and status signals of the capture FIFO
interface adc_sample_fifo_if
  import adc_sample_fifo_pkg::*;
#(
  parameter int DATA_W = ADC_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W,
  parameter int DROP_W = FIFO_DROP_W
);
  logic clear_in;
  logic [DATA_W-1:0] data_in;
  logic data_valid_in;
  logic rd_en_in;
  logic [DATA_W-1:0] rd_data_out;
  logic rd_valid_out;
  logic [ADDR_W:0] level_out;
  logic empty_out;
  logic full_out;
  logic [ADDR_W:0] threshold_in;
  logic irq_out;
  logic overflow_out;
  logic [DROP_W-1:0] drop_count_out;
  modport master (
    output clear_in, data_in, data_valid_in, rd_en_in, threshold_in,
    input rd_data_out, rd_valid_out, level_out, empty_out, full_out, irq_out, overflow_out, drop_count_out
  );
  modport slave (
    input clear_in, data_in, data_valid_in, rd_en_in, threshold_in,
    output rd_data_out, rd_valid_out, level_out, empty_out, full_out, irq_out, overflow_out, drop_count_out
  );
endinterface

// File: rtl/adc_sample_fifo_mem.sv
// adc_fifo_mem: DEPTH x DATA_W storage, one write port and one registered read port
module adc_fifo_mem
  import adc_sample_fifo_pkg::*;
#(
  parameter int DATA_W = ADC_DATA_W,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              flush_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rd_data_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  always_ff @(posedge clk) if (we_i) mem_q[waddr_i] <= wdata_i;
  // only the output register is flushed; array contents survive reset
  always_ff @(posedge clk) rd_data_q <= flush_i ? '0 : re_i ? mem_q[raddr_i] : rd_data_q;
  assign rd_data_o = rd_data_q;
endmodule

// File: rtl/adc_sample_fifo.sv
// adc_sample_fifo: capture FIFO behind vco_adc with level, threshold irq, sticky overflow and drop count
module adc_sample_fifo
  import adc_sample_fifo_pkg::*;
#(
  parameter int DATA_W = ADC_DATA_W,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int ADDR_W = FIFO_ADDR_W,
  parameter int DROP_W = FIFO_DROP_W
) (
  input logic clk,
  input logic rst,
  adc_sample_fifo_if.slave bus
);
  logic flush, empty, full, rd_acc, wr_acc, drop;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] level_q, level_d;
  logic ovf_q, ovf_d, rd_valid_q;
  logic [DROP_W-1:0] drop_q, drop_d;
  always_comb begin
    flush = rst || bus.clear_in;
    empty = level_q == '0;
    full = level_q == (ADDR_W+1)'(DEPTH);
    rd_acc = bus.rd_en_in && !empty;
    wr_acc = bus.data_valid_in && (!full || rd_acc);
    drop = bus.data_valid_in && !wr_acc;
    wr_ptr_d = flush ? '0 : wr_ptr_q + ADDR_W'(wr_acc);
    rd_ptr_d = flush ? '0 : rd_ptr_q + ADDR_W'(rd_acc);
    level_d = flush ? '0 : level_q + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_acc);
    ovf_d = !flush && (ovf_q || drop);
    drop_d = flush ? '0 : drop_q + DROP_W'(drop && drop_q != '1);
  end
  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    level_q <= level_d;
    ovf_q <= ovf_d;
    drop_q <= drop_d;
    rd_valid_q <= !flush && rd_acc;
  end
  adc_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk(clk),
    .flush_i(flush),
    .we_i(wr_acc && !flush),
    .waddr_i(wr_ptr_q),
    .wdata_i(bus.data_in),
    .re_i(rd_acc && !flush),
    .raddr_i(rd_ptr_q),
    .rd_data_o(bus.rd_data_out)
  );
  assign bus.rd_valid_out = rd_valid_q;
  assign bus.level_out = level_q;
  assign bus.empty_out = empty;
  assign bus.full_out = full;
  assign bus.irq_out = bus.threshold_in != '0 && level_q >= bus.threshold_in;
  assign bus.overflow_out = ovf_q;
  assign bus.drop_count_out = drop_q;
endmodule
